// File: rtl/mul_wb_merge.sv
// mul_wb_merge: merges the non-stallable multiplier writeback with the main
// pipeline writeback onto one register-file write port. Colliding main-pipeline
// writes wait in a 2-entry ordered queue that is forwarded to decode.
module mul_wb_merge #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_we,
  input  logic [4:0]            alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  mul_valid,
  input  logic [4:0]            mul_rd,
  input  logic [DATA_WIDTH-1:0] mul_data,
  input  logic [4:0]            q_rs1,
  input  logic [4:0]            q_rs2,
  output logic                  rf_we,
  output logic [4:0]            rf_rd,
  output logic [DATA_WIDTH-1:0] rf_data,
  output logic                  stall,
  output logic                  fwd1_hit,
  output logic                  fwd2_hit,
  output logic [DATA_WIDTH-1:0] fwd1_data,
  output logic [DATA_WIDTH-1:0] fwd2_data,
  output logic [1:0]            q_count
);

  localparam int unsigned RW    = 5;
  localparam int unsigned CNT_W = 2;

  typedef struct packed {
    logic [RW-1:0]         rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_t;

  // Entry 0 is the head (oldest); entries at index >= cnt_q are don't-care.
  wb_t              ent_q [2];
  wb_t              ent_d [2];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic mul_req;
  logic alu_req;
  logic full;
  logic q_nonempty;

  // Effective requests; x0 writes are dropped and ALU input is masked when full.
  always_comb begin
    full       = (cnt_q == CNT_W'(DEPTH));
    q_nonempty = (cnt_q != '0);
    mul_req    = mul_valid && (mul_rd != '0);
    alu_req    = alu_we && (alu_rd != '0) && !full;
  end

  // Register-file port select: multiplier, then queue head, then direct ALU.
  always_comb begin
    rf_we   = 1'b0;
    rf_rd   = '0;
    rf_data = '0;
    if (!rst) begin
      if (mul_req) begin
        rf_we   = 1'b1;
        rf_rd   = mul_rd;
        rf_data = mul_data;
      end else if (q_nonempty) begin
        rf_we   = 1'b1;
        rf_rd   = ent_q[0].rd;
        rf_data = ent_q[0].data;
      end else if (alu_req) begin
        rf_we   = 1'b1;
        rf_rd   = alu_rd;
        rf_data = alu_data;
      end
    end
  end

  // Queue next state: squash/pop, compact toward the head, then append.
  always_comb begin
    logic             keep0;
    logic             keep1;
    logic             enq;
    logic [CNT_W-1:0] n;

    ent_d[0] = ent_q[0];
    ent_d[1] = ent_q[1];
    cnt_d    = cnt_q;

    // Survivors: a multiplier write to the same rd makes a queued entry
    // obsolete; without a multiplier write the head is drained instead.
    keep0 = (cnt_q >= CNT_W'(1)) && !(mul_req && (ent_q[0].rd == mul_rd));
    keep1 = (cnt_q == CNT_W'(2)) && !(mul_req && (ent_q[1].rd == mul_rd));
    if (!mul_req && q_nonempty) begin
      keep0 = 1'b0;
    end

    // Compaction keeps valid entries contiguous from the head.
    if (!keep0) begin
      ent_d[0] = ent_q[1];
    end
    n = CNT_W'(keep0) + CNT_W'(keep1);

    // The ALU write is deferred only when the port is taken this cycle;
    // it lands behind the survivors and is never squashed by this cycle's mul.
    enq = alu_req && (mul_req || q_nonempty);
    if (enq) begin
      if (n == '0) begin
        ent_d[0] = '{rd: alu_rd, data: alu_data};
      end else begin
        ent_d[1] = '{rd: alu_rd, data: alu_data};
      end
      n = n + CNT_W'(1);
    end
    cnt_d = n;
  end

  // Queue state, updated on the falling edge alongside the multiplier stages.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      cnt_q    <= '0;
    end else begin
      ent_q[0] <= ent_d[0];
      ent_q[1] <= ent_d[1];
      cnt_q    <= cnt_d;
    end
  end

  // Stall and occupancy; both read zero while reset is asserted.
  always_comb begin
    stall   = full && !rst;
    q_count = rst ? '0 : cnt_q;
  end

  // Decode forwarding: youngest valid match wins, x0 never hits.
  always_comb begin
    logic h10;
    logic h11;
    logic h20;
    logic h21;

    h10 = !rst && (cnt_q >= CNT_W'(1)) && (ent_q[0].rd == q_rs1) && (q_rs1 != '0);
    h11 = !rst && (cnt_q == CNT_W'(2)) && (ent_q[1].rd == q_rs1) && (q_rs1 != '0);
    h20 = !rst && (cnt_q >= CNT_W'(1)) && (ent_q[0].rd == q_rs2) && (q_rs2 != '0);
    h21 = !rst && (cnt_q == CNT_W'(2)) && (ent_q[1].rd == q_rs2) && (q_rs2 != '0);

    fwd1_hit  = h10 || h11;
    fwd2_hit  = h20 || h21;
    fwd1_data = '0;
    fwd2_data = '0;
    if (h11) begin
      fwd1_data = ent_q[1].data;
    end else if (h10) begin
      fwd1_data = ent_q[0].data;
    end
    if (h21) begin
      fwd2_data = ent_q[1].data;
    end else if (h20) begin
      fwd2_data = ent_q[0].data;
    end
  end

endmodule

// File: tb/tb_mul_wb_merge.sv
// Directed scoreboard bench for mul_wb_merge: expected register-file writes are
// queued in program order and a monitor pops one per observed write.
module tb_mul_wb_merge;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_we;
  logic [4:0]    alu_rd;
  logic [DW-1:0] alu_data;
  logic          mul_valid;
  logic [4:0]    mul_rd;
  logic [DW-1:0] mul_data;
  logic [4:0]    q_rs1;
  logic [4:0]    q_rs2;
  logic          rf_we;
  logic [4:0]    rf_rd;
  logic [DW-1:0] rf_data;
  logic          stall;
  logic          fwd1_hit;
  logic          fwd2_hit;
  logic [DW-1:0] fwd1_data;
  logic [DW-1:0] fwd2_data;
  logic [1:0]    q_count;

  mul_wb_merge #(.DATA_WIDTH(DW), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_we    (alu_we),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mul_valid (mul_valid),
    .mul_rd    (mul_rd),
    .mul_data  (mul_data),
    .q_rs1     (q_rs1),
    .q_rs2     (q_rs2),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_data   (rf_data),
    .stall     (stall),
    .fwd1_hit  (fwd1_hit),
    .fwd2_hit  (fwd2_hit),
    .fwd1_data (fwd1_data),
    .fwd2_data (fwd2_data),
    .q_count   (q_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, got, want, $time);
    end
  endfunction

  task automatic push(input logic [4:0] rd, input logic [DW-1:0] data);
    wr_t w;
    w.rd   = rd;
    w.data = data;
    exp_q.push_back(w);
  endtask

  // Inputs change just after the falling (active) edge.
  task automatic drive(input logic mv, input logic [4:0] mrd, input logic [DW-1:0] mdat,
                       input logic aw, input logic [4:0] ard, input logic [DW-1:0] adat,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    @(negedge clk);
    #1;
    mul_valid = mv;  mul_rd = mrd;  mul_data = mdat;
    alu_we    = aw;  alu_rd = ard;  alu_data = adat;
    q_rs1     = rs1; q_rs2  = rs2;
  endtask

  // Drive a cycle, then sample just after the mid-cycle rising edge.
  task automatic step(input logic mv, input logic [4:0] mrd, input logic [DW-1:0] mdat,
                      input logic aw, input logic [4:0] ard, input logic [DW-1:0] adat,
                      input logic [4:0] rs1, input logic [4:0] rs2);
    drive(mv, mrd, mdat, aw, ard, adat, rs1, rs2);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every observed write must be the next expected one; idle port is zero.
  always @(posedge clk) begin
    wr_t e;
    if (!rst) begin
      if (rf_we) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rf_unexpected: got write x%0d=0x%0h required no write (t=%0t)",
                   rf_rd, rf_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rf_rd", 32'(rf_rd), 32'(e.rd));
          chk("rf_data", rf_data, e.data);
        end
      end else begin
        chk("idle_rf_rd", 32'(rf_rd), 32'd0);
        chk("idle_rf_data", rf_data, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    mul_valid = 1'b1; mul_rd = 5'd3; mul_data = 32'h55;
    alu_we = 1'b0; alu_rd = '0; alu_data = '0;
    q_rs1 = 5'd3; q_rs2 = '0;
    #1 rst = 1'b1;

    // Reset holds the port quiet even with a multiplier request present
    @(posedge clk); #1;
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_rd", 32'(rf_rd), 32'd0);
    chk("rst_rf_data", rf_data, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_q_count", 32'(q_count), 32'd0);
    chk("rst_fwd1_hit", 32'(fwd1_hit), 32'd0);
    #2 rst = 1'b0;

    // Direct ALU path
    push(5'd5, 32'hAAAA);
    step(0, 0, 0, 1, 5'd5, 32'hAAAA, 0, 0);
    chk("direct_rf_we", 32'(rf_we), 32'd1);
    chk("direct_q_count", 32'(q_count), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("direct_q_after", 32'(q_count), 32'd0);
    chk("direct_idle_we", 32'(rf_we), 32'd0);

    // Collision then drain, with forwarding of the deferred value
    push(5'd3, 32'h12); push(5'd7, 32'h34);
    step(1, 5'd3, 32'h12, 1, 5'd7, 32'h34, 0, 0);
    chk("coll_q_c0", 32'(q_count), 32'd0);
    step(0, 0, 0, 0, 0, 0, 5'd7, 5'd3);
    chk("coll_q_c1", 32'(q_count), 32'd1);
    chk("coll_fwd1_hit", 32'(fwd1_hit), 32'd1);
    chk("coll_fwd1_data", fwd1_data, 32'h34);
    chk("coll_fwd2_hit", 32'(fwd2_hit), 32'd0);
    chk("coll_fwd2_data", fwd2_data, 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("coll_q_c2", 32'(q_count), 32'd0);

    // Fill, stall, drain in order; the held third ALU write lands after stall drops
    push(5'd1, 32'h101); push(5'd2, 32'h102); push(5'd4, 32'h104);
    push(5'd10, 32'hA0); push(5'd11, 32'hA1); push(5'd12, 32'hA2);
    step(1, 5'd1, 32'h101, 1, 5'd10, 32'hA0, 0, 0);
    step(1, 5'd2, 32'h102, 1, 5'd11, 32'hA1, 0, 0);
    chk("fill_q_b", 32'(q_count), 32'd1);
    chk("fill_stall_b", 32'(stall), 32'd0);
    step(1, 5'd4, 32'h104, 1, 5'd12, 32'hA2, 0, 0);
    chk("fill_q_c", 32'(q_count), 32'd2);
    chk("fill_stall_c", 32'(stall), 32'd1);
    step(0, 0, 0, 1, 5'd12, 32'hA2, 5'd11, 5'd10);
    chk("fill_q_d", 32'(q_count), 32'd2);
    chk("fill_stall_d", 32'(stall), 32'd1);
    chk("fill_fwd1_data", fwd1_data, 32'hA1);
    chk("fill_fwd2_data", fwd2_data, 32'hA0);
    step(0, 0, 0, 1, 5'd12, 32'hA2, 0, 0);
    chk("fill_q_e", 32'(q_count), 32'd1);
    chk("fill_stall_e", 32'(stall), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("fill_q_f", 32'(q_count), 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("fill_q_g", 32'(q_count), 32'd0);

    // WAW squash of both entries; youngest of two same-rd entries forwards
    push(5'd1, 32'h11); push(5'd2, 32'h22); push(5'd9, 32'h2);
    step(1, 5'd1, 32'h11, 1, 5'd9, 32'h1, 0, 0);
    step(1, 5'd2, 32'h22, 1, 5'd9, 32'h5, 5'd9, 0);
    chk("waw_fwd_old", fwd1_data, 32'h1);
    step(1, 5'd9, 32'h2, 0, 0, 0, 5'd9, 0);
    chk("waw_q_pre", 32'(q_count), 32'd2);
    chk("waw_fwd_young", fwd1_data, 32'h5);
    step(0, 0, 0, 0, 0, 0, 5'd9, 0);
    chk("waw_q_post", 32'(q_count), 32'd0);
    chk("waw_fwd_hit", 32'(fwd1_hit), 32'd0);
    chk("waw_fwd_data", fwd1_data, 32'd0);

    // Squash of the head only: tail compacts to the head
    push(5'd1, 32'h31); push(5'd2, 32'h32); push(5'd5, 32'h35);
    push(5'd6, 32'hB); push(5'd8, 32'hC);
    step(1, 5'd1, 32'h31, 1, 5'd5, 32'hA, 0, 0);
    step(1, 5'd2, 32'h32, 1, 5'd6, 32'hB, 0, 0);
    step(1, 5'd5, 32'h35, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 5'd8, 32'hC, 5'd6, 5'd5);
    chk("cmp_q", 32'(q_count), 32'd1);
    chk("cmp_fwd1_data", fwd1_data, 32'hB);
    chk("cmp_fwd2_hit", 32'(fwd2_hit), 32'd0);
    step(0, 0, 0, 0, 0, 0, 5'd8, 0);
    chk("cmp_q2", 32'(q_count), 32'd1);
    chk("cmp_fwd_new", fwd1_data, 32'hC);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("cmp_q3", 32'(q_count), 32'd0);

    // Same-edge enqueue survives a squash of the same rd
    push(5'd1, 32'h41); push(5'd4, 32'h44); push(5'd4, 32'hD2);
    step(1, 5'd1, 32'h41, 1, 5'd4, 32'hD1, 0, 0);
    step(1, 5'd4, 32'h44, 1, 5'd4, 32'hD2, 0, 0);
    step(0, 0, 0, 0, 0, 0, 5'd4, 0);
    chk("sq_enq_q", 32'(q_count), 32'd1);
    chk("sq_enq_fwd", fwd1_data, 32'hD2);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("sq_enq_q2", 32'(q_count), 32'd0);

    // x0: mul to x0 lets the head drain; ALU to x0 is dropped
    push(5'd1, 32'h51); push(5'd3, 32'hE1);
    step(1, 5'd1, 32'h51, 1, 5'd3, 32'hE1, 0, 0);
    step(1, 5'd0, 32'h99, 0, 0, 0, 0, 0);
    chk("x0_mul_rf_rd", 32'(rf_rd), 32'd3);
    step(0, 0, 0, 1, 5'd0, 32'h77, 5'd0, 0);
    chk("x0_alu_we", 32'(rf_we), 32'd0);
    chk("x0_fwd_hit", 32'(fwd1_hit), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("x0_q", 32'(q_count), 32'd0);

    // Asynchronous reset mid-cycle with a full queue discards it
    push(5'd1, 32'h61); push(5'd2, 32'h62); push(5'd3, 32'h63);
    step(1, 5'd1, 32'h61, 1, 5'd20, 32'hF0, 0, 0);
    step(1, 5'd2, 32'h62, 1, 5'd21, 32'hF1, 0, 0);
    step(1, 5'd3, 32'h63, 0, 0, 0, 5'd20, 0);
    chk("mrst_pre_q", 32'(q_count), 32'd2);
    chk("mrst_pre_stall", 32'(stall), 32'd1);
    chk("mrst_pre_fwd", fwd1_data, 32'hF0);
    #1 rst = 1'b1;
    #1;
    chk("mrst_q", 32'(q_count), 32'd0);
    chk("mrst_stall", 32'(stall), 32'd0);
    chk("mrst_rf_we", 32'(rf_we), 32'd0);
    chk("mrst_fwd_hit", 32'(fwd1_hit), 32'd0);
    chk("mrst_fwd_data", fwd1_data, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step(0, 0, 0, 0, 0, 0, 5'd20, 0);
    chk("mrst_after_q", 32'(q_count), 32'd0);
    chk("mrst_after_we", 32'(rf_we), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mul_wb_merge.md
# mul_wb_merge

Writeback merge stage placed directly downstream of the 4-cycle multiplier pipeline. It merges the multiplier's output (result, Rd, regmul flag) with the main pipeline's writeback onto the single register-file write port. The multiplier pipeline cannot stall, so it always has priority. Colliding main-pipeline writes are deferred in a 2-entry ordered queue, and the block stalls the main pipeline when that queue is full. Deferred values are forwarded to decode so that register reads never see stale data.

## Interface
Parameters:
- DATA_WIDTH, 32, register data width
- DEPTH, 2, deferred-write queue entries (fixed at 2 for this design; count is 2 bits)

Ports:
- clk  in  1  clock; all state updates on the falling edge, matching the multiplier pipeline registers
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- alu_we  in  1  main-pipeline writeback request
- alu_rd  in  5  main-pipeline destination register
- alu_data  in  DATA_WIDTH  main-pipeline writeback value
- mul_valid  in  1  multiplier result valid (regmul flag from last mul stage)
- mul_rd  in  5  multiplier destination register
- mul_data  in  DATA_WIDTH  multiplier result
- q_rs1, q_rs2  in  5 each  decode-stage source registers for forwarding lookup
- rf_we  out  1  register-file write enable
- rf_rd  out  5  register-file write address
- rf_data  out  DATA_WIDTH  register-file write data
- stall  out  1  main pipeline must hold its writeback inputs
- fwd1_hit, fwd2_hit  out  1 each  queued value exists for q_rs1 / q_rs2
- fwd1_data, fwd2_data  out  DATA_WIDTH each  youngest queued value for that register
- q_count  out  2  number of valid queue entries (0..2)

## Operation
- Effective requests: mul_req = mul_valid && mul_rd != 0; alu_req = alu_we && alu_rd != 0 && !stall. Writes to x0 are dropped and never queued.
- Port select, evaluated in priority order each cycle:
  - mul_req: the multiplier writes. If alu_req is also set, the ALU write is enqueued.
  - else if queue not empty: the queue head is written and dequeued. An alu_req in the same cycle is enqueued, behind the existing entries.
  - else if alu_req: the ALU write goes directly to the port and nothing is enqueued.
  - else: rf_we = 0.
- Idle-cycle values: when rf_we = 0, rf_rd = 0 and rf_data = 0.
- stall = (q_count == 2). While stall is high, alu_* inputs are ignored and upstream holds them.
- Ordering: entries drain oldest-first.
- WAW squash: when mul_req writes Rd = r, every queued entry with rd == r is invalidated in the same edge, because it is older than the multiplier write.
  - The queue compacts so that valid entries stay contiguous from the head.
  - The same-cycle enqueued ALU write is not squashed. It counts as younger and is written later.
- Forwarding:
  - fwdN_hit = 1 if any valid queued entry has rd == q_rsN and q_rsN != 0.
  - fwdN_data = the youngest matching entry's data; 0 on a miss.
  - Forwarding does not look at the current-cycle rf_* write; the register file handles that itself.

## Timing
- rf_*, stall, fwd*, and q_count are combinational from the inputs and the registered queue. The queue updates on the falling edge of clk.
- A direct ALU write has 0 added latency. Deferred writes have latency 1 + (entries ahead of them) + (intervening mul_req cycles).
- Reset, asynchronous: the queue is emptied immediately and q_count = 0. While rst = 1, outputs are held as follows:
  - rf_we = 0, rf_rd = 0, rf_data = 0
  - stall = 0
  - fwd*_hit = 0, fwd*_data = 0
- Reset in the middle of operation discards queued writes. Upstream is reset at the same time.
- Simultaneous enqueue and dequeue when q_count = 1 and there is no mul_req: the head is written, the new entry becomes the head, and q_count stays 1.
- Full queue with continuous mul_req: nothing drains and stall stays 1 until the first cycle without mul_req.
- q_count never exceeds 2, because alu_req is masked while stall is high.
- A squash and an enqueue in the same edge resolve in this order: squash first, then compaction, then append.

## Test plan
- Reset, no requests: rf_we = 0, stall = 0, q_count = 0. Assert rst mid-cycle with q_count = 2: q_count goes to 0 and stall goes to 0 immediately.
- Direct path: alu_we = 1, alu_rd = 5, alu_data = 0xAAAA, mul_valid = 0 → rf_we = 1, rf_rd = 5, rf_data = 0xAAAA in the same cycle, and q_count stays 0.
- Collision then drain:
  - Cycle 0: mul (rd = 3, data = 0x12) and alu (rd = 7, data = 0x34) together → rf writes x3 = 0x12 and q_count becomes 1.
  - Cycle 1: no requests → rf writes x7 = 0x34 and q_count becomes 0.
  - During cycle 1, q_rs1 = 7 gives fwd1_hit = 1 and fwd1_data = 0x34.
- Fill and stall:
  - Issue three consecutive cycles of mul+alu collisions. After two edges, q_count = 2 and stall = 1, and the third ALU write is ignored.
  - After mul_valid drops, the queue drains in order over 2 cycles and stall drops once q_count falls below 2.
- WAW squash: queue holds x9 = 0x1. mul writes x9 = 0x2 → the entry is removed, q_count drops by 1, x9 is never rewritten with 0x1, and fwd on x9 gives hit = 0.
- x0 handling: mul_rd = 0 with a queued entry present → the queued entry drains that cycle. alu_rd = 0 → rf_we = 0 and nothing is enqueued.
